// File: rtl/alu_step_ctrl.sv
// Multicycle control FSM for the shared ALU datapath: sequences fetch, decode,
// execute, memory and writeback, and raises a one-cycle exception pulse with a held cause.
module alu_step_ctrl #(
   parameter int WAIT_LIMIT = 16,
   parameter int CW         = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   input  logic       overflow,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       exception,
   output logic [1:0] cause,
   output logic [3:0] state_out
);

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WR = 4'd7,
      S_WB_ALU = 4'd8,
      S_WB_MEM = 4'd9,
      S_BRANCH = 4'd10,
      S_EXCPT  = 4'd11
   } state_t;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] FN_ADD    = 6'h20;
   localparam logic [5:0] FN_SUB    = 6'h22;
   localparam logic [5:0] FN_AND    = 6'h24;
   localparam logic [5:0] FN_OR     = 6'h25;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;

   localparam logic [1:0] CAUSE_BADOP   = 2'b01;
   localparam logic [1:0] CAUSE_OVF     = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

   state_t          state, nextState;
   logic [CW-1:0]   waitCnt;
   logic [1:0]      causeQ, nextCause;
   logic            regDstQ;
   logic            waitState;
   logic            atLimit;

   assign waitState = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign atLimit   = (waitCnt == LIMIT_M1);
   assign cause     = causeQ;
   assign state_out = state;

   // State, cause and the wait counter; the counter only runs while a memory wait state repeats
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_RESET;
         waitCnt <= '0;
         causeQ  <= 2'b00;
         regDstQ <= 1'b0;
      end else begin
         state  <= nextState;
         causeQ <= nextCause;
         if (state == S_DECODE) begin
            regDstQ <= (opcode == OPC_RTYPE);
         end
         if (waitState && !mem_ready && (nextState == state)) begin
            waitCnt <= waitCnt + CW'(1);
         end else begin
            waitCnt <= '0;
         end
      end
   end

   // Next-state dispatch and the per-state datapath controls
   always_comb begin
      nextState     = state;
      nextCause     = causeQ;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      exception     = 1'b0;
      case (state)
         S_RESET: nextState = S_FETCH;
         S_FETCH: begin
            mem_rd    = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = OP_ADD;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) begin
               nextState = S_DECODE;
            end else if (atLimit) begin
               nextState = S_EXCPT;
               nextCause = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_op    = OP_ADD;
            case (opcode)
               OPC_RTYPE:      nextState = S_EXEC_R;
               OPC_ADDI:       nextState = S_EXEC_I;
               OPC_LW, OPC_SW: nextState = S_ADDR;
               OPC_BEQ:        nextState = S_BRANCH;
               default: begin
                  nextState = S_EXCPT;
                  nextCause = CAUSE_BADOP;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            nextState = S_WB_ALU;
            case (funct)
               FN_ADD, FN_SUB: begin
                  alu_op = (funct == FN_ADD) ? OP_ADD : OP_SUB;
                  if (overflow) begin
                     nextState = S_EXCPT;
                     nextCause = CAUSE_OVF;
                  end
               end
               FN_AND: alu_op = OP_AND;
               FN_OR:  alu_op = OP_OR;
               default: begin
                  nextState = S_EXCPT;
                  nextCause = CAUSE_BADOP;
               end
            endcase
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = OP_ADD;
            if (overflow) begin
               nextState = S_EXCPT;
               nextCause = CAUSE_OVF;
            end else begin
               nextState = S_WB_ALU;
            end
         end
         S_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = OP_ADD;
            nextState = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD, S_MEM_WR: begin
            mem_rd = (state == S_MEM_RD);
            mem_wr = (state == S_MEM_WR);
            if (mem_ready) begin
               nextState = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
            end else if (atLimit) begin
               nextState = S_EXCPT;
               nextCause = CAUSE_TIMEOUT;
            end
         end
         S_WB_ALU: begin
            reg_write = 1'b1;
            reg_dst   = regDstQ;
            nextState = S_FETCH;
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            nextState  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = OP_SUB;
            pc_write_cond = 1'b1;
            nextState     = S_FETCH;
         end
         S_EXCPT: begin
            exception = 1'b1;
            nextState = S_FETCH;
         end
         default: nextState = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Scoreboard bench for alu_step_ctrl: an instruction-level model expands each
// instruction into expected per-cycle controls, and a monitor compares them every cycle.
module tb_alu_step_ctrl;

   localparam int LIMIT = 16;

   typedef struct packed {
      logic [3:0] st;
      logic       srcA;
      logic [1:0] srcB;
      logic [2:0] op;
      logic       memRd;
      logic       memWr;
      logic       irWrite;
      logic       pcWrite;
      logic       pcWriteCond;
      logic       regWrite;
      logic       memToReg;
      logic       regDst;
      logic       exc;
      logic [1:0] cause;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       mem_ready, overflow;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       mem_rd, mem_wr, ir_write, pc_write, pc_write_cond;
   logic       reg_write, mem_to_reg, reg_dst, exception;
   logic [1:0] cause;
   logic [3:0] state_out;

   exp_t       expQ[$];
   int         nChecks = 0;
   int         nFails  = 0;
   logic [1:0] expCause = 2'b00;

   alu_step_ctrl #(.WAIT_LIMIT(LIMIT), .CW(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .overflow(overflow),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_write(ir_write), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst), .exception(exception), .cause(cause), .state_out(state_out)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] actualVec();
      return {state_out, alu_src_a, alu_src_b, alu_op, mem_rd, mem_wr, ir_write, pc_write,
              pc_write_cond, reg_write, mem_to_reg, reg_dst, exception, cause};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nChecks++;
      if (act !== expv) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic exp_t blank(input logic [3:0] st);
      exp_t e;
      e       = '0;
      e.st    = st;
      e.cause = expCause;
      return e;
   endfunction

   task automatic applyStimulus(input exp_t e, input logic mr, input logic ov);
      mem_ready = mr;
      overflow  = ov;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic doExcpt(input logic [1:0] c);
      exp_t e;
      expCause = c;
      e        = blank(4'd11);
      e.exc    = 1'b1;
      applyStimulus(e, rbit(), rbit());
   endtask

   // One memory wait phase: 'stall' low cycles then a ready cycle, or a timeout at LIMIT
   task automatic memPhase(input logic [3:0] st, input int stall, output bit timedOut);
      exp_t e;
      timedOut = 1'b0;
      for (int i = 0; i < LIMIT; i++) begin
         e = blank(st);
         if (st == 4'd1) begin
            e.memRd   = 1'b1;
            e.srcB    = 2'b01;
            e.op      = 3'b001;
            e.irWrite = (i == stall);
            e.pcWrite = (i == stall);
         end else if (st == 4'd6) begin
            e.memRd = 1'b1;
         end else begin
            e.memWr = 1'b1;
         end
         applyStimulus(e, (i == stall), rbit());
         if (i == stall) return;
      end
      timedOut = 1'b1;
      doExcpt(2'b11);
   endtask

   task automatic runInstr(input logic [5:0] opc, input logic [5:0] fn, input logic ov,
                           input int stallF, input int stallM);
      exp_t e;
      bit   to;
      opcode = opc;
      funct  = fn;
      memPhase(4'd1, stallF, to);
      if (to) return;
      e      = blank(4'd2);
      e.srcB = 2'b11;
      e.op   = 3'b001;
      applyStimulus(e, rbit(), rbit());
      case (opc)
         6'h00: begin
            e      = blank(4'd3);
            e.srcA = 1'b1;
            e.op   = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 :
                     (fn == 6'h24) ? 3'b011 : (fn == 6'h25) ? 3'b100 : 3'b000;
            applyStimulus(e, rbit(), ov);
            if (e.op == 3'b000) doExcpt(2'b01);
            else if (ov && (fn == 6'h20 || fn == 6'h22)) doExcpt(2'b10);
            else begin
               e          = blank(4'd8);
               e.regWrite = 1'b1;
               e.regDst   = 1'b1;
               applyStimulus(e, rbit(), rbit());
            end
         end
         6'h08: begin
            e      = blank(4'd4);
            e.srcA = 1'b1;
            e.srcB = 2'b10;
            e.op   = 3'b001;
            applyStimulus(e, rbit(), ov);
            if (ov) doExcpt(2'b10);
            else begin
               e          = blank(4'd8);
               e.regWrite = 1'b1;
               applyStimulus(e, rbit(), rbit());
            end
         end
         6'h23, 6'h2B: begin
            e      = blank(4'd5);
            e.srcA = 1'b1;
            e.srcB = 2'b10;
            e.op   = 3'b001;
            applyStimulus(e, rbit(), rbit());
            memPhase((opc == 6'h23) ? 4'd6 : 4'd7, stallM, to);
            if (!to && opc == 6'h23) begin
               e          = blank(4'd9);
               e.regWrite = 1'b1;
               e.memToReg = 1'b1;
               applyStimulus(e, rbit(), rbit());
            end
         end
         6'h04: begin
            e             = blank(4'd10);
            e.srcA        = 1'b1;
            e.op          = 3'b010;
            e.pcWriteCond = 1'b1;
            applyStimulus(e, rbit(), rbit());
         end
         default: doExcpt(2'b01);
      endcase
   endtask

   function automatic int pickStall();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return $urandom_range(0, 2);
      if (r == 7) return LIMIT - 1;
      return LIMIT;
   endfunction

   // Monitor: every cycle with an expectation pending is compared at the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("cycle_st%0d", e.st), 32'(actualVec()), 32'(e));
            checkOutput("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
            checkOutput("regwrite_with_rd", 32'(reg_write & mem_rd), 32'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [5:0] fnTab [5];
      bit         to;
      exp_t       e;
      int         k;
      logic [5:0] opc;
      fnTab[0] = 6'h20; fnTab[1] = 6'h22; fnTab[2] = 6'h24; fnTab[3] = 6'h25; fnTab[4] = 6'h2A;

      reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; overflow = 1'b0;
      #3;
      checkOutput("reset_outputs", 32'(actualVec()), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      applyStimulus(blank(4'd0), 1'b1, 1'b0);

      runInstr(6'h00, 6'h20, 1'b0, 0, 0);
      runInstr(6'h23, 6'h00, 1'b0, 0, 3);
      runInstr(6'h3F, 6'h00, 1'b0, 0, 0);
      runInstr(6'h08, 6'h00, 1'b1, 0, 0);
      runInstr(6'h00, 6'h20, 1'b0, LIMIT, 0);
      runInstr(6'h00, 6'h22, 1'b0, LIMIT - 1, 0);
      runInstr(6'h00, 6'h24, 1'b1, 0, 0);
      runInstr(6'h2B, 6'h00, 1'b0, 1, LIMIT);
      runInstr(6'h23, 6'h00, 1'b0, 0, LIMIT - 1);
      runInstr(6'h04, 6'h00, 1'b1, 0, 0);

      // Asynchronous reset while a store is waiting on memory
      opcode = 6'h2B; funct = 6'h00;
      memPhase(4'd1, 0, to);
      e = blank(4'd2); e.srcB = 2'b11; e.op = 3'b001;
      applyStimulus(e, 1'b0, 1'b0);
      e = blank(4'd5); e.srcA = 1'b1; e.srcB = 2'b10; e.op = 3'b001;
      applyStimulus(e, 1'b0, 1'b0);
      e = blank(4'd7); e.memWr = 1'b1;
      applyStimulus(e, 1'b0, 1'b0);
      mem_ready = 1'b0;
      #2;
      checkOutput("memwr_before_reset", 32'(mem_wr), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("memwr_async_drop", 32'(mem_wr), 32'd0);
      checkOutput("state_async_reset", 32'(state_out), 32'd0);
      checkOutput("outputs_async_reset", 32'(actualVec()), 32'd0);
      expCause = 2'b00;
      @(posedge clk); #1;
      reset = 1'b0;
      applyStimulus(blank(4'd0), rbit(), rbit());

      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 9);
         if (k < 4) opc = 6'h00;
         else if (k == 4) opc = 6'h08;
         else if (k == 5) opc = 6'h23;
         else if (k == 6) opc = 6'h2B;
         else if (k == 7) opc = 6'h04;
         else begin
            opc = 6'($urandom_range(0, 63));
            while (opc == 6'h00 || opc == 6'h08 || opc == 6'h23 || opc == 6'h2B || opc == 6'h04)
               opc = 6'($urandom_range(0, 63));
         end
         runInstr(opc, fnTab[$urandom_range(0, 4)], ($urandom_range(0, 3) == 0),
                  pickStall(), pickStall());
      end

      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
